// File: rtl/rs_link_pkg.sv
// Shared definitions for the bit-serial Reed-Solomon symbol link.
// Parity behaviour is enabled in the receivers by the SIPO_PARITY_EN macro.
package rs_link_pkg;

   localparam int SYM_W = 7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } sipo_state_e;

   // 1'b0 selects even parity: data bits plus parity bit XOR to zero.
   localparam logic PARITY_POLARITY = 1'b0;

   function automatic logic parity_mismatch(input logic [31:0] data, input logic pbit);
      return (^data) ^ pbit ^ PARITY_POLARITY;
   endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// One-deep valid/ready holding register; a load while full and not being
// drained is dropped and reported as a one-cycle overrun pulse.
module sipo_out_reg
   import rs_link_pkg::*;
#(
   parameter int W = SYM_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         ready,
   output logic [W-1:0] data_out,
   output logic         data_valid,
   output logic         overrun
);

   logic can_load_s;

   assign can_load_s = !data_valid || ready;

   // Holding register: load when empty or draining this cycle, else drop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= load && !can_load_s;
         if (load && can_load_s) begin
            data_out   <= load_data;
            data_valid <= 1'b1;
         end else if (data_valid && ready) begin
            data_valid <= 1'b0;
         end else begin
            data_valid <= data_valid;
         end
      end
   end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out symbol receiver, MSB first, with framing and overrun flags.
// Defining SIPO_PARITY_EN adds a trailing even-parity bit and the parity_err port.
module sipo_rx
   import rs_link_pkg::*;
#(
   parameter int N = SYM_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         serial_in,
   input  logic         serial_en,
   output logic [N-1:0] data_out,
   output logic         data_valid,
   input  logic         data_ready,
   output logic         frame_err,
`ifdef SIPO_PARITY_EN
   output logic         parity_err,
`endif
   output logic         overrun
);

   localparam int CW = $clog2(N + 1);

   sipo_state_e   state_r, state_s;
   logic [CW-1:0] bit_cnt_r, bit_cnt_s;
   logic          last_bit_s;
   logic          complete_s;
   logic          break_s;
   logic [N-1:0]  symbol_s;

`ifdef SIPO_PARITY_EN
   logic [N-1:0]  shift_r, shift_s, shifted_s;
   logic          parity_bad_s;

   // All N data bits are already held when the parity bit arrives.
   assign shifted_s    = {shift_r[N-2:0], serial_in};
   assign symbol_s     = shift_r;
   assign parity_bad_s = parity_mismatch(32'(shift_r), serial_in);
`else
   // Only N-1 bits need storing: the last bit goes straight into the symbol.
   logic [N-2:0]  shift_r, shift_s, shifted_s;
   logic [N-1:0]  full_s;

   assign full_s    = {shift_r, serial_in};
   assign shifted_s = full_s[N-2:0];
   assign symbol_s  = full_s;
`endif

   assign last_bit_s = (bit_cnt_r == CW'(N - 1));

   // State, counter, shift register and flag registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         bit_cnt_r <= '0;
         shift_r   <= '0;
         frame_err <= 1'b0;
`ifdef SIPO_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         state_r   <= state_s;
         bit_cnt_r <= bit_cnt_s;
         shift_r   <= shift_s;
         frame_err <= break_s;
`ifdef SIPO_PARITY_EN
         parity_err <= complete_s && (!data_valid || data_ready) && parity_bad_s;
`endif
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (serial_en) state_s = SHIFT;
            else           state_s = IDLE;
         end
         SHIFT: begin
            if (!serial_en) begin
               state_s = IDLE;
            end else if (last_bit_s) begin
`ifdef SIPO_PARITY_EN
               state_s = PARITY;
`else
               state_s = IDLE;
`endif
            end else begin
               state_s = SHIFT;
            end
         end
`ifdef SIPO_PARITY_EN
         PARITY:  state_s = IDLE;
`endif
         default: state_s = IDLE;
      endcase
   end

   // Datapath controls: shifting, bit count, completion and framing break.
   always_comb begin
      shift_s    = shift_r;
      bit_cnt_s  = '0;
      complete_s = 1'b0;
      break_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (serial_en) begin
               shift_s   = shifted_s;
               bit_cnt_s = CW'(1);
            end else begin
               shift_s   = shift_r;
            end
         end
         SHIFT: begin
            if (serial_en) begin
               shift_s = shifted_s;
               if (last_bit_s) begin
`ifndef SIPO_PARITY_EN
                  complete_s = 1'b1;
`endif
                  bit_cnt_s  = '0;
               end else begin
                  bit_cnt_s  = bit_cnt_r + CW'(1);
               end
            end else begin
               break_s = 1'b1;
               shift_s = '0;
            end
         end
`ifdef SIPO_PARITY_EN
         PARITY: begin
            shift_s = '0;
            if (serial_en) complete_s = 1'b1;
            else           break_s    = 1'b1;
         end
`endif
         default: begin
            shift_s = '0;
         end
      endcase
   end

   sipo_out_reg #(.W(N)) u_out_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (complete_s),
      .load_data  (symbol_s),
      .ready      (data_ready),
      .data_out   (data_out),
      .data_valid (data_valid),
      .overrun    (overrun)
   );

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: a frame-level model predicts symbols and flags,
// a negedge monitor compares. Honours SIPO_PARITY_EN when defined.
module tb_sipo_rx;
   import rs_link_pkg::*;

   localparam int N = 7;
`ifdef SIPO_PARITY_EN
   localparam int FRAME = N + 1;
`else
   localparam int FRAME = N;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         serial_in = 1'b0;
   logic         serial_en = 1'b0;
   logic         data_ready = 1'b0;
   logic [N-1:0] data_out;
   logic         data_valid;
   logic         frame_err;
   logic         overrun;
`ifdef SIPO_PARITY_EN
   logic         parity_err;
`endif

   sipo_rx #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .serial_in  (serial_in),
      .serial_en  (serial_en),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .frame_err  (frame_err),
`ifdef SIPO_PARITY_EN
      .parity_err (parity_err),
`endif
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int edge_n;
      bit fe;
      bit ov;
      bit pe;
      bit vld;
      bit rst;
   } exp_t;

   exp_t flag_q[$];
   int   sym_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   // Model state: bits of the frame in progress and output-slot occupancy.
   int   m_bits = 0;
   int   m_sym = 0;
   int   m_pbit = 0;
   bit   m_occ = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
      end
   endtask

   // Drive one cycle of inputs and predict the effect of the edge that samples them.
   task automatic step(input bit en, input bit b, input bit rdy, input bit rstn);
      exp_t e;
      bit   done;
      bit   pe;
      int   sym_done;
      @(posedge clk);
      #1;
      serial_en  = en;
      serial_in  = b;
      data_ready = rdy;
      rst_n      = rstn;
      done = 1'b0; pe = 1'b0; sym_done = 0;
      e.edge_n = cyc + 1; e.fe = 1'b0; e.ov = 1'b0; e.pe = 1'b0; e.rst = !rstn;
      if (!rstn) begin
         m_bits = 0; m_sym = 0; m_occ = 1'b0;
         sym_q.delete();
      end else begin
         if (en) begin
            if (m_bits < N) m_sym = m_sym * 2 + int'(b);
            else            m_pbit = int'(b);
            m_bits++;
            if (m_bits == FRAME) begin
               done     = 1'b1;
               sym_done = m_sym;
               pe       = (FRAME > N) && ((($countones(m_sym) + m_pbit) % 2) == 1);
               m_bits   = 0;
               m_sym    = 0;
            end
         end else begin
            if (m_bits > 0) e.fe = 1'b1;
            m_bits = 0;
            m_sym  = 0;
         end
         if (done) begin
            if (!m_occ || rdy) begin
               sym_q.push_back(sym_done);
               m_occ = 1'b1;
               e.pe  = pe;
            end else begin
               e.ov = 1'b1;
            end
         end else if (m_occ && rdy) begin
            m_occ = 1'b0;
         end
      end
      e.vld = m_occ;
      flag_q.push_back(e);
   endtask

   task automatic idle(input int n, input bit rdy);
      repeat (n) step(1'b0, 1'b0, rdy, 1'b1);
   endtask

   // rmode: 0 ready low, 1 ready high, 2 random ready.
   task automatic send(input int v, input int rmode, input bit bad_par);
      bit rdy;
      for (int i = N - 1; i >= 0; i--) begin
         rdy = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
         step(1'b1, v[i], rdy, 1'b1);
      end
      if (FRAME > N) begin
         rdy = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
         step(1'b1, 1'((($countones(v) % 2) == 1) ^ bad_par), rdy, 1'b1);
      end
   endtask

   // Monitor: check accepted symbols, then per-edge flag predictions.
   always @(negedge clk) begin
      exp_t me;
      if (rst_n && data_valid && data_ready) begin
         if (sym_q.size() == 0) begin
            chk("accept_unexpected", int'(data_out), -1);
         end else begin
            chk("data_out", int'(data_out), sym_q.pop_front());
         end
      end
      while (flag_q.size() > 0 && flag_q[0].edge_n <= cyc) begin
         me = flag_q.pop_front();
         chk("data_valid", int'(data_valid), int'(me.vld));
         chk("frame_err", int'(frame_err), int'(me.fe));
         chk("overrun", int'(overrun), int'(me.ov));
`ifdef SIPO_PARITY_EN
         chk("parity_err", int'(parity_err), int'(me.pe));
`endif
         if (me.rst) chk("reset_data_out", int'(data_out), 0);
      end
   end

   initial begin
      int r;
      int k;
      repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);

      send(32'h59, 1, 1'b0);
      idle(3, 1'b1);

      send(32'h59, 1, 1'b0);
      send(32'h26, 1, 1'b0);
      idle(3, 1'b1);

      send(32'h59, 0, 1'b0);
      send(32'h26, 0, 1'b0);
      idle(2, 1'b0);
      idle(3, 1'b1);

      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      idle(1, 1'b1);
      send(32'h7F, 1, 1'b0);
      idle(3, 1'b1);

      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      send(32'h01, 1, 1'b0);
      idle(3, 1'b1);

      if (FRAME > N) begin
         send(32'h59, 1, 1'b0);
         idle(2, 1'b1);
         send(32'h59, 1, 1'b1);
         idle(2, 1'b1);
      end

      for (int it = 0; it < 400; it++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0) begin
            k = int'($urandom_range(1, FRAME - 1));
            for (int j = 0; j < k; j++)
               step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
         end else if (r == 1) begin
            repeat (int'($urandom_range(1, 2))) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
         end else begin
            send(int'($urandom_range(0, 127)), 2, ($urandom_range(0, 3) == 0));
         end
         repeat (int'($urandom_range(0, 2))) idle(1, 1'($urandom_range(0, 1)));
      end

      idle(5, 1'b1);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("symbols_left", sym_q.size(), 0);
      chk("flags_left", flag_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
